// File: rtl/frogger_pkg.sv
// Shared constants and types for the Frogger timing/motion core.
// Holds tile geometry, grid size, default VGA timing and default mover settings.
// Ports: none (package).
package frogger_pkg;

  localparam int TILE_SIZE  = 32;
  localparam int TILE_SHIFT = 5;
  localparam int GRID_COLS  = 14;
  localparam int GRID_ROWS  = 13;

  localparam int TOTAL_COLS  = 800;
  localparam int TOTAL_ROWS  = 525;
  localparam int ACTIVE_COLS = 640;
  localparam int ACTIVE_ROWS = 480;

  localparam int CAR_SPEED      = 1;
  localparam int CAR_SLOW_COUNT = 4000000;
  localparam int CAR_INIT_X     = 0;
  localparam int CAR_INIT_Y     = 11;

  localparam int LOG_SPEED      = 1;
  localparam int LOG_SLOW_COUNT = 39000000;
  localparam int LOG_MIN_X      = 0;
  localparam int LOG_INIT_X     = 13;
  localparam int LOG_Y_1        = 1;
  localparam int LOG_Y_2        = 3;
  localparam int LOG_Y_3        = 5;

  localparam int CNT_W  = 10;
  localparam int DIV_W  = CNT_W - TILE_SHIFT;
  localparam int POS_W  = 6;
  localparam int TICK_W = 26;

  typedef logic [CNT_W-1:0] pix_cnt_t;
  typedef logic [DIV_W-1:0] tile_idx_t;
  typedef logic [POS_W-1:0] tile_pos_t;

  // Truncate an integer tile coordinate to the 6-bit position width.
  function automatic tile_pos_t to_pos(input int v);
    return tile_pos_t'(v);
  endfunction

endpackage

// File: rtl/frogger_motion_timebase_if.sv
// Bundle between the timing/motion core and the renderer/collision logic.
// Ports: raw syncs in; delayed syncs, pixel counters, tile indices, car/log positions out.
// master = timebase core (drives outputs), slave = consumer (drives raw syncs).
interface frogger_motion_timebase_if;

  logic                   i_HSync;
  logic                   i_VSync;
  logic                   o_HSync;
  logic                   o_VSync;
  frogger_pkg::pix_cnt_t  o_Col_Count;
  frogger_pkg::pix_cnt_t  o_Row_Count;
  frogger_pkg::tile_idx_t o_Col_Count_Div;
  frogger_pkg::tile_idx_t o_Row_Count_Div;
  frogger_pkg::tile_pos_t o_Car_X;
  frogger_pkg::tile_pos_t o_Car_Y;
  frogger_pkg::tile_pos_t o_Log_X_1;
  frogger_pkg::tile_pos_t o_Log_X_2;
  frogger_pkg::tile_pos_t o_Log_X_3;
  frogger_pkg::tile_pos_t o_Log_Y_1;
  frogger_pkg::tile_pos_t o_Log_Y_2;
  frogger_pkg::tile_pos_t o_Log_Y_3;

  modport master (
    input  i_HSync, i_VSync,
    output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Col_Count_Div, o_Row_Count_Div,
    output o_Car_X, o_Car_Y, o_Log_X_1, o_Log_X_2, o_Log_X_3, o_Log_Y_1, o_Log_Y_2, o_Log_Y_3
  );

  modport slave (
    output i_HSync, i_VSync,
    input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Col_Count_Div, o_Row_Count_Div,
    input  o_Car_X, o_Car_Y, o_Log_X_1, o_Log_X_2, o_Log_X_3, o_Log_Y_1, o_Log_Y_2, o_Log_Y_3
  );

endinterface

// File: rtl/frogger_motion_timebase_tile_mover.sv
// Purpose: steps one tile X position by SPEED every SLOW_COUNT clocks, wrapping at the grid edge.
// Latency: position changes on the SLOW_COUNT-th edge after reset release, then every SLOW_COUNT edges.
// Backpressure: none; free-running.
// Ports: clk_i, rst_n_i (sync active-low), x_o (current tile X).
module tile_mover
  import frogger_pkg::*;
#(
  parameter int DIR        = 1,   // +1 moves right, -1 moves left
  parameter int SPEED      = 1,
  parameter int SLOW_COUNT = 4,
  parameter int INIT_X     = 0,
  parameter int LIMIT      = 14   // right: wrap bound (exclusive); left: minimum X
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  output tile_pos_t x_o
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SLOW_COUNT - 1);
  localparam logic [POS_W:0]    SPEED_E   = (POS_W+1)'(SPEED);
  localparam logic [POS_W:0]    LIMIT_E   = (POS_W+1)'(LIMIT);
  localparam tile_pos_t         INIT_POS  = to_pos(INIT_X);
  localparam bit                RIGHT     = (DIR > 0);

  logic [TICK_W-1:0] tick_q, tick_d;
  tile_pos_t         x_q, x_d;
  logic              tick;
  logic [POS_W:0]    x_ext;

  assign tick  = (tick_q == TICK_LAST);
  assign x_ext = {1'b0, x_q};

  always_comb begin
    tick_d = tick ? '0 : tick_q + TICK_W'(1);
    x_d    = x_q;
    if (tick) begin
      if (RIGHT) begin
        // Compare one bit wider so X+SPEED cannot overflow past the bound.
        if (x_ext + SPEED_E >= LIMIT_E) x_d = '0;
        else                            x_d = x_q + SPEED_E[POS_W-1:0];
      end else begin
        // Test before subtracting so X never underflows below the minimum.
        if (x_ext < LIMIT_E + SPEED_E) x_d = INIT_POS;
        else                           x_d = x_q - SPEED_E[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tick_q <= '0;
      x_q    <= INIT_POS;
    end else begin
      tick_q <= tick_d;
      x_q    <= x_d;
    end
  end

  assign x_o = x_q;

endmodule

// File: rtl/frogger_motion_timebase.sv
// Purpose: re-registers VGA syncs, derives pixel/tile counters, and moves the car and logs.
// Latency: syncs and counters 1 clock; tile indices are slices of registered counters.
// Backpressure: none; free-running pixel-clock pipeline.
// Ports: i_Clk, i_Rst_L (sync active-low), bus (master side of frogger_motion_timebase_if).
module frogger_motion_timebase
  import frogger_pkg::*;
#(
  parameter int c_TOTAL_COLS     = TOTAL_COLS,
  parameter int c_TOTAL_ROWS     = TOTAL_ROWS,
  parameter int c_MAX_X          = GRID_COLS,
  parameter int c_CAR_SPEED      = CAR_SPEED,
  parameter int c_CAR_SLOW_COUNT = CAR_SLOW_COUNT,
  parameter int c_CAR_INIT_X     = CAR_INIT_X,
  parameter int c_CAR_INIT_Y     = CAR_INIT_Y,
  parameter int c_LOG_SPEED      = LOG_SPEED,
  parameter int c_LOG_SLOW_COUNT = LOG_SLOW_COUNT,
  parameter int c_LOG_MIN_X      = LOG_MIN_X,
  parameter int c_LOG_INIT_X     = LOG_INIT_X,
  parameter int c_LOG_Y_1        = LOG_Y_1,
  parameter int c_LOG_Y_2        = LOG_Y_2,
  parameter int c_LOG_Y_3        = LOG_Y_3
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  frogger_motion_timebase_if.master   bus
);

  localparam pix_cnt_t COL_LAST = pix_cnt_t'(c_TOTAL_COLS - 1);
  localparam pix_cnt_t ROW_LAST = pix_cnt_t'(c_TOTAL_ROWS - 1);

  logic      hsync_q, vsync_q;
  pix_cnt_t  col_q, col_d, row_q, row_d;
  logic      frame_start;
  tile_pos_t car_x, log_x;

  // Rising VSync edge, seen against the previous registered copy.
  assign frame_start = bus.i_VSync & ~vsync_q;

  always_comb begin
    col_d = col_q + pix_cnt_t'(1);
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + pix_cnt_t'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      hsync_q <= bus.i_HSync;
      vsync_q <= bus.i_VSync;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  tile_mover #(
    .DIR(1), .SPEED(c_CAR_SPEED), .SLOW_COUNT(c_CAR_SLOW_COUNT),
    .INIT_X(c_CAR_INIT_X), .LIMIT(c_MAX_X)
  ) u_car (
    .clk_i(i_Clk), .rst_n_i(i_Rst_L), .x_o(car_x)
  );

  // One mover feeds all three logs so they can never drift out of phase.
  tile_mover #(
    .DIR(-1), .SPEED(c_LOG_SPEED), .SLOW_COUNT(c_LOG_SLOW_COUNT),
    .INIT_X(c_LOG_INIT_X), .LIMIT(c_LOG_MIN_X)
  ) u_log (
    .clk_i(i_Clk), .rst_n_i(i_Rst_L), .x_o(log_x)
  );

  assign bus.o_HSync         = hsync_q;
  assign bus.o_VSync         = vsync_q;
  assign bus.o_Col_Count     = col_q;
  assign bus.o_Row_Count     = row_q;
  assign bus.o_Col_Count_Div = col_q[CNT_W-1:TILE_SHIFT];
  assign bus.o_Row_Count_Div = row_q[CNT_W-1:TILE_SHIFT];
  assign bus.o_Car_X         = car_x;
  assign bus.o_Car_Y         = to_pos(c_CAR_INIT_Y);
  assign bus.o_Log_X_1       = log_x;
  assign bus.o_Log_X_2       = log_x;
  assign bus.o_Log_X_3       = log_x;
  assign bus.o_Log_Y_1       = to_pos(c_LOG_Y_1);
  assign bus.o_Log_Y_2       = to_pos(c_LOG_Y_2);
  assign bus.o_Log_Y_3       = to_pos(c_LOG_Y_3);

endmodule

// File: tb/tb_frogger_motion_timebase.sv
module tb_frogger_motion_timebase;

  typedef struct {
    int   col;
    int   row;
    int   car;
    int   log;
    logic hs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  frogger_motion_timebase_if bus_if ();

  frogger_motion_timebase #(
    .c_CAR_SLOW_COUNT(4),
    .c_LOG_SLOW_COUNT(3)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus_if)
  );

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.i_HSync = 1'b1;
    bus_if.i_VSync = 1'b1;
    repeat (3) step();
    checks++; if (bus_if.o_Col_Count !== 10'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", bus_if.o_Col_Count); end
    checks++; if (bus_if.o_Row_Count !== 10'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", bus_if.o_Row_Count); end
    checks++; if (bus_if.o_Col_Count_Div !== 5'd0) begin errors++; $display("FAIL reset_coldiv: got %0d expected 0", bus_if.o_Col_Count_Div); end
    checks++; if (bus_if.o_Row_Count_Div !== 5'd0) begin errors++; $display("FAIL reset_rowdiv: got %0d expected 0", bus_if.o_Row_Count_Div); end
    checks++; if (bus_if.o_Car_X !== 6'd0) begin errors++; $display("FAIL reset_car_x: got %0d expected 0", bus_if.o_Car_X); end
    checks++; if (bus_if.o_Car_Y !== 6'd11) begin errors++; $display("FAIL reset_car_y: got %0d expected 11", bus_if.o_Car_Y); end
    checks++; if (bus_if.o_Log_X_1 !== 6'd13) begin errors++; $display("FAIL reset_log_x1: got %0d expected 13", bus_if.o_Log_X_1); end
    checks++; if (bus_if.o_Log_X_2 !== 6'd13) begin errors++; $display("FAIL reset_log_x2: got %0d expected 13", bus_if.o_Log_X_2); end
    checks++; if (bus_if.o_Log_X_3 !== 6'd13) begin errors++; $display("FAIL reset_log_x3: got %0d expected 13", bus_if.o_Log_X_3); end
    checks++; if (bus_if.o_Log_Y_1 !== 6'd1) begin errors++; $display("FAIL reset_log_y1: got %0d expected 1", bus_if.o_Log_Y_1); end
    checks++; if (bus_if.o_Log_Y_2 !== 6'd3) begin errors++; $display("FAIL reset_log_y2: got %0d expected 3", bus_if.o_Log_Y_2); end
    checks++; if (bus_if.o_Log_Y_3 !== 6'd5) begin errors++; $display("FAIL reset_log_y3: got %0d expected 5", bus_if.o_Log_Y_3); end
    checks++; if (bus_if.o_HSync !== 1'b0) begin errors++; $display("FAIL reset_hsync: got %b expected 0", bus_if.o_HSync); end
    checks++; if (bus_if.o_VSync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", bus_if.o_VSync); end
    bus_if.i_HSync = 1'b0;
    bus_if.i_VSync = 1'b0;
  endtask

  // Car steps every 4 edges (0..13 wrap), logs every 3 edges (13..0 wrap);
  // HSync is random and must reappear one edge later.
  task automatic test_motion();
    exp_t e, g;
    logic hs;
    rst_n = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      hs = 1'($urandom_range(0, 1));
      bus_if.i_HSync = hs;
      e.col = n; e.row = 0; e.car = (n / 4) % 14; e.log = 13 - ((n / 3) % 14); e.hs = hs;
      sb.push_back(e);
      step();
      cyc = n;
      g = sb.pop_front();
      checks++; if (bus_if.o_Car_X !== 6'(g.car)) begin errors++; $display("FAIL motion_car_x@%0d: got %0d expected %0d", n, bus_if.o_Car_X, g.car); end
      checks++; if (bus_if.o_Log_X_1 !== 6'(g.log)) begin errors++; $display("FAIL motion_log_x1@%0d: got %0d expected %0d", n, bus_if.o_Log_X_1, g.log); end
      checks++; if (bus_if.o_Log_X_2 !== 6'(g.log)) begin errors++; $display("FAIL motion_log_x2@%0d: got %0d expected %0d", n, bus_if.o_Log_X_2, g.log); end
      checks++; if (bus_if.o_Log_X_3 !== 6'(g.log)) begin errors++; $display("FAIL motion_log_x3@%0d: got %0d expected %0d", n, bus_if.o_Log_X_3, g.log); end
      checks++; if (bus_if.o_HSync !== g.hs) begin errors++; $display("FAIL motion_hsync@%0d: got %b expected %b", n, bus_if.o_HSync, g.hs); end
      checks++; if (bus_if.o_Col_Count !== 10'(g.col)) begin errors++; $display("FAIL motion_col@%0d: got %0d expected %0d", n, bus_if.o_Col_Count, g.col); end
    end
    bus_if.i_HSync = 1'b0;
  endtask

  task automatic test_counter_wrap();
    exp_t e, g;
    for (int n = cyc + 1; n <= 801; n++) begin
      e.col = n % 800; e.row = n / 800; e.car = 0; e.log = 0; e.hs = 1'b0;
      sb.push_back(e);
      step();
      cyc = n;
      g = sb.pop_front();
      checks++; if (bus_if.o_Col_Count !== 10'(g.col)) begin errors++; $display("FAIL wrap_col@%0d: got %0d expected %0d", n, bus_if.o_Col_Count, g.col); end
      checks++; if (bus_if.o_Row_Count !== 10'(g.row)) begin errors++; $display("FAIL wrap_row@%0d: got %0d expected %0d", n, bus_if.o_Row_Count, g.row); end
    end
  endtask

  task automatic test_tile_divide();
    while (cyc < 70 * 800 + 100) begin
      step();
      cyc++;
    end
    checks++; if (bus_if.o_Col_Count !== 10'd100) begin errors++; $display("FAIL div_col: got %0d expected 100", bus_if.o_Col_Count); end
    checks++; if (bus_if.o_Row_Count !== 10'd70) begin errors++; $display("FAIL div_row: got %0d expected 70", bus_if.o_Row_Count); end
    checks++; if (bus_if.o_Col_Count_Div !== 5'd3) begin errors++; $display("FAIL div_coldiv: got %0d expected 3", bus_if.o_Col_Count_Div); end
    checks++; if (bus_if.o_Row_Count_Div !== 5'd2) begin errors++; $display("FAIL div_rowdiv: got %0d expected 2", bus_if.o_Row_Count_Div); end
  endtask

  task automatic test_frame_start();
    checks++; if (bus_if.o_VSync !== 1'b0) begin errors++; $display("FAIL fs_vsync_pre: got %b expected 0", bus_if.o_VSync); end
    bus_if.i_VSync = 1'b1;
    step();
    checks++; if (bus_if.o_Col_Count !== 10'd0) begin errors++; $display("FAIL fs_col0: got %0d expected 0", bus_if.o_Col_Count); end
    checks++; if (bus_if.o_Row_Count !== 10'd0) begin errors++; $display("FAIL fs_row0: got %0d expected 0", bus_if.o_Row_Count); end
    checks++; if (bus_if.o_VSync !== 1'b1) begin errors++; $display("FAIL fs_vsync: got %b expected 1", bus_if.o_VSync); end
    step();
    checks++; if (bus_if.o_Col_Count !== 10'd1) begin errors++; $display("FAIL fs_col1: got %0d expected 1", bus_if.o_Col_Count); end
    checks++; if (bus_if.o_Row_Count !== 10'd0) begin errors++; $display("FAIL fs_row1: got %0d expected 0", bus_if.o_Row_Count); end
    bus_if.i_VSync = 1'b0;
    step();
    checks++; if (bus_if.o_Col_Count !== 10'd2) begin errors++; $display("FAIL fs_col2: got %0d expected 2", bus_if.o_Col_Count); end
    checks++; if (bus_if.o_VSync !== 1'b0) begin errors++; $display("FAIL fs_vsync_low: got %b expected 0", bus_if.o_VSync); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e, g;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 28) begin
        checks++; if (bus_if.o_Car_X !== 6'd7) begin errors++; $display("FAIL mid_car_pre: got %0d expected 7", bus_if.o_Car_X); end
      end
    end
    // Next edge would move the car 7->8; reset must win.
    rst_n = 1'b0;
    step();
    checks++; if (bus_if.o_Car_X !== 6'd0) begin errors++; $display("FAIL mid_car_x: got %0d expected 0", bus_if.o_Car_X); end
    checks++; if (bus_if.o_Log_X_1 !== 6'd13) begin errors++; $display("FAIL mid_log_x1: got %0d expected 13", bus_if.o_Log_X_1); end
    checks++; if (bus_if.o_Log_X_3 !== 6'd13) begin errors++; $display("FAIL mid_log_x3: got %0d expected 13", bus_if.o_Log_X_3); end
    checks++; if (bus_if.o_Col_Count !== 10'd0) begin errors++; $display("FAIL mid_col: got %0d expected 0", bus_if.o_Col_Count); end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      e.col = k; e.row = 0; e.car = (k / 4) % 14; e.log = 13 - ((k / 3) % 14); e.hs = 1'b0;
      sb.push_back(e);
      step();
      g = sb.pop_front();
      checks++; if (bus_if.o_Car_X !== 6'(g.car)) begin errors++; $display("FAIL mid_restart_car@%0d: got %0d expected %0d", k, bus_if.o_Car_X, g.car); end
      checks++; if (bus_if.o_Log_X_2 !== 6'(g.log)) begin errors++; $display("FAIL mid_restart_log@%0d: got %0d expected %0d", k, bus_if.o_Log_X_2, g.log); end
      checks++; if (bus_if.o_Col_Count !== 10'(g.col)) begin errors++; $display("FAIL mid_restart_col@%0d: got %0d expected %0d", k, bus_if.o_Col_Count, g.col); end
    end
  endtask

  initial begin
    bus_if.i_HSync = 1'b0;
    bus_if.i_VSync = 1'b0;
    test_reset();
    test_motion();
    test_counter_wrap();
    test_tile_divide();
    test_frame_start();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frogger_motion_timebase.md
Name: frogger_motion_timebase

Overview:
- Timing and motion core for the Frogger VGA game.
- Re-registers incoming VGA sync pulses and derives the pixel column/row counters and 32-pixel tile indices from them.
- Moves one car (left to right) and three floating logs (right to left) across the 14-column tile grid at slow, parameterised rates.
- Feeds the renderer and collision logic in frogger_game.

Parameters:
- c_TOTAL_COLS, 800, total pixel columns per line including blanking.
- c_TOTAL_ROWS, 525, total lines per frame including blanking.
- c_MAX_X, 14, number of tile columns; the car wraps within 0..c_MAX_X-1.
- c_CAR_SPEED, 1, tiles added to car X per move.
- c_CAR_SLOW_COUNT, 4000000, clocks between car moves.
- c_CAR_INIT_X, 0, car X after reset.
- c_CAR_INIT_Y, 11, car tile row (constant).
- c_LOG_SPEED, 1, tiles subtracted from log X per move.
- c_LOG_SLOW_COUNT, 39000000, clocks between log moves (shared by all logs).
- c_LOG_MIN_X, 0, leftmost log X before wrap.
- c_LOG_INIT_X, 13, log X after reset and after wrap.
- c_LOG_Y_1 / c_LOG_Y_2 / c_LOG_Y_3, 1 / 3 / 5, log tile rows (constant).

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  synchronous active-low reset.
- i_HSync  in  1  raw horizontal sync.
- i_VSync  in  1  raw vertical sync.
- o_HSync  out  1  i_HSync delayed one clock.
- o_VSync  out  1  i_VSync delayed one clock.
- o_Col_Count  out  10  pixel column.
- o_Row_Count  out  10  pixel row.
- o_Col_Count_Div  out  5  o_Col_Count[9:5].
- o_Row_Count_Div  out  5  o_Row_Count[9:5].
- o_Car_X, o_Car_Y  out  6 each  car tile position.
- o_Log_X_1..3, o_Log_Y_1..3  out  6 each  log tile positions.

Behaviour:
- Reset: all registers update only on rising i_Clk. While i_Rst_L=0 at an edge:
  - o_HSync = 0, o_VSync = 0.
  - Col/row counters = 0.
  - Car X = c_CAR_INIT_X.
  - Log X = c_LOG_INIT_X.
  - Both slow-move counters = 0.
  - Y outputs always equal their row parameters, zero-extended to 6 bits.
- Sync path:
  - o_HSync/o_VSync are registered copies of the inputs (latency 1).
  - Frame start = i_VSync==1 while o_VSync==0, i.e. a rising VSync edge.
- Counters:
  - On frame start, col = 0 and row = 0.
  - Otherwise col increments each clock.
  - When col == c_TOTAL_COLS-1, col wraps to 0 and row increments.
  - When row == c_TOTAL_ROWS-1 at that same column wrap, row wraps to 0.
  - Frame start has priority over normal counting.
- Tile indices are combinational slices of the registered counters (no extra latency).
- Move tick:
  - Each mover has a 26-bit counter incrementing every clock.
  - When the counter == SLOW_COUNT-1, it returns to 0 and the position updates on that same edge.
  - The first move therefore occurs on the SLOW_COUNT-th clock after reset is released.
- Car move:
  - If X + c_CAR_SPEED >= c_MAX_X, X = 0.
  - Else X = X + c_CAR_SPEED.
  - With defaults: 0,1,…,13,0.
- Log move:
  - If X < c_LOG_MIN_X + c_LOG_SPEED, X = c_LOG_INIT_X.
  - Else X = X - c_LOG_SPEED.
  - With defaults: 13,12,…,0,13.
  - All three logs share one tick and stay in phase.
- Mid-operation reset: a reset asserted at any point overrides the tick and counting on that edge and restores the reset values.
- Movers run independently of the sync inputs.

Decomposition:
- Shared package frogger_pkg holds:
  - tile size 32 and grid dimensions 14×13;
  - default total/active VGA dimensions;
  - default speeds, slow counts and rows.
- Sub-module tile_mover:
  - parameters DIR (+1/-1), SPEED, SLOW_COUNT, INIT_X, LIMIT;
  - instantiated once for the car and three times for the logs (or once with three outputs).
  - The counter logic stays in the top level.

Test Plan:
- Reset: hold i_Rst_L=0 for 3 clocks, then release. Required: counters 0, Car X=0 Y=11, Log X=13, Log Y=1/3/5, syncs 0.
- Counter wrap and frame start:
  - With c_TOTAL_COLS=800 and i_VSync held low, col goes 799→0 and row 0→1 on that edge.
  - Raise i_VSync mid-line: on the next edge col=0, row=0, and o_VSync goes 1 one clock after i_VSync.
- Tile divide: at col=100, row=70 → o_Col_Count_Div=3, o_Row_Count_Div=2.
- Car timing (c_CAR_SLOW_COUNT=4):
  - X changes 0→1 exactly on the 4th clock after reset release.
  - After 14 moves (56 clocks) X=0 again.
- Log timing (c_LOG_SLOW_COUNT=3):
  - X goes 13→12 after 3 clocks.
  - After 13 moves X=0; the 14th move gives X=13.
  - All three logs are always equal.
- Reset mid-run: assert i_Rst_L=0 when Car X=7 on the same edge as a tick. Required: X=0, Log X=13, and the slow counters restart from 0.
